// File: rtl/booth_dot_accumulator.sv
// booth_dot_accumulator: streams signed 32x32 pairs through a radix-4 Booth multiplier into a saturating 64-bit dot-product accumulator
//   Booth ports: A, B (32-bit signed operands), P (64-bit signed product)
//   top ports: clk, rst (async active-high), start, in_valid/in_ready/A/B (operand handshake),
//              out_valid/out_ready/S/ovf (result handshake, S mirrors the accumulator), busy (not IDLE)
module Booth (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] P
);
  logic [32:0] bx;
  logic [63:0] am;
  assign bx = {B, 1'b0};
  assign am = {{32{A[31]}}, A};
  function automatic logic [63:0] booth_pp(input logic [2:0] s, input logic [63:0] a);
    logic [63:0] m;
    m = (s[0] ^ s[1]) ? a : ((s == 3'b011) || (s == 3'b100)) ? a << 1 : '0;
    return s[2] ? -m : m;
  endfunction
  always_comb begin
    P = '0;
    for (int i = 0; i < 16; i++) P = P + (booth_pp(bx[2*i +: 3], am) << (2*i));
  end
endmodule

module booth_dot_accumulator #(
  parameter int LEN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] S,
  output logic        ovf,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [7:0] last = 8'(LEN - 1);
  state_t state, nxt;
  logic [31:0] a1, b1;
  logic [63:0] p, p2, acc;
  logic [64:0] sum;
  logic [7:0] cnt;
  logic v1, v2, accept, clear, pos_of, neg_of;
  Booth u_booth (.A(a1), .B(b1), .P(p));
  assign accept = (state == RUN) && in_valid;
  assign clear = (state == IDLE) && start;
  assign sum = {acc[63], acc} + {p2[63], p2};
  // the 65-bit sign and bit 63 disagree only when the true sum left the 64-bit range
  assign pos_of = !sum[64] && sum[63];
  assign neg_of = sum[64] && !sum[63];
  assign in_ready = (state == RUN);
  assign out_valid = (state == DONE);
  assign busy = (state != IDLE);
  assign S = acc;
  always_comb begin
    nxt = state;
    nxt = (state == IDLE) ? (start ? RUN : IDLE) :
          (state == RUN) ? ((accept && cnt == last) ? DRAIN : RUN) :
          (state == DRAIN) ? ((!v1 && !v2) ? DONE : DRAIN) :
          (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a1 <= '0;
      b1 <= '0;
      v1 <= 1'b0;
      p2 <= '0;
      v2 <= 1'b0;
      cnt <= '0;
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      state <= nxt;
      v1 <= accept;
      if (accept) begin
        a1 <= A;
        b1 <= B;
        cnt <= cnt + 8'd1;
      end
      p2 <= p;
      v2 <= v1;
      if (clear) begin
        acc <= '0;
        ovf <= 1'b0;
        cnt <= '0;
      end else if (v2) begin
        acc <= pos_of ? 64'h7FFF_FFFF_FFFF_FFFF : neg_of ? 64'h8000_0000_0000_0000 : sum[63:0];
        ovf <= ovf || pos_of || neg_of;
      end
    end
  end
endmodule

// File: tb/tb_booth_dot_accumulator.sv
// tb_booth_dot_accumulator: directed self-checking bench for booth_dot_accumulator
module tb_booth_dot_accumulator;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic in_ready, out_valid, ovf, busy;
  logic [63:0] s;
  logic [31:0] va [8], vb [8];
  int n_chk = 0, n_fail = 0;
  booth_dot_accumulator #(.LEN(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready), .S(s), .ovf(ovf), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_dot(input string tag, input bit bub, input logic [63:0] es, input logic eo);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_run_rdy"}, 64'(in_ready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      if (bub) begin
        in_valid = 1'b0;
        tick();
        if (i == 4) repeat (5) tick();
        check({tag, "_bubble_rdy"}, 64'(in_ready), 64'd1);
      end
      in_valid = 1'b1;
      a = va[i];
      b = vb[i];
      tick();
    end
    in_valid = 1'b0;
    check({tag, "_drain_rdy"}, 64'(in_ready), 64'd0);
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd3);
    check({tag, "_S"}, s, es);
    check({tag, "_ovf"}, 64'(ovf), 64'(eo));
  endtask
  task automatic release_out(input string tag, input logic [63:0] es);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_low"}, 64'(out_valid), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_S_held"}, s, es);
  endtask
  initial begin
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_S", s, 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_no_start", 64'(busy), 64'd0);
    va = '{32'd0, 32'd1, -32'sd7, -32'sd7, 32'd0, -32'sd1, 32'd1, -32'sd1};
    vb = '{-32'sd3, -32'sd3, -32'sd7, 32'd7, 32'd0, -32'sd1, 32'd1, 32'd1};
    run_dot("basic", 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    release_out("basic", 64'hFFFF_FFFF_FFFF_FFFE);
    run_dot("bubble", 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    release_out("bubble", 64'hFFFF_FFFF_FFFF_FFFE);
    for (int i = 0; i < 8; i++) begin
      va[i] = 32'h8000_0000;
      vb[i] = 32'h8000_0000;
    end
    run_dot("sat_pos", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    release_out("sat_pos", 64'h7FFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 8; i++) vb[i] = 32'h7FFF_FFFF;
    run_dot("sat_neg", 1'b0, 64'h8000_0000_0000_0000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      start = i[0];
      in_valid = !i[0];
      tick();
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_S", s, 64'h8000_0000_0000_0000);
      check("bp_ovf", 64'(ovf), 64'd1);
    end
    start = 1'b0;
    in_valid = 1'b0;
    release_out("sat_neg", 64'h8000_0000_0000_0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 32'd5;
      b = 32'd5;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_S", s, 64'd0);
    check("abort_ovf", 64'(ovf), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      va[i] = 32'd1;
      vb[i] = 32'd1;
    end
    run_dot("restart", 1'b0, 64'd8, 1'b0);
    release_out("restart", 64'd8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
